// File: rtl/wb_pkg.sv
// Shared widths and entry type for the register-file write-back path.
package wb_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// Producer handshakes, register-file write port and pending-write query bus.
interface wb_writeback_unit_if;
  import wb_pkg::*;

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          load_valid;
  logic [AW-1:0] load_rd;
  logic [DW-1:0] load_data;
  logic          load_ready;

  logic [AW-1:0] WB_address_wr;
  logic          WB_write_1;
  logic [DW-1:0] WB_data_wb_out1;

  logic [AW-1:0] pend_query1;
  logic [AW-1:0] pend_query2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic          busy;

  modport master (
    output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
    output pend_query1, pend_query2,
    input  alu_ready, load_ready, WB_address_wr, WB_write_1, WB_data_wb_out1,
    input  pend_hit1, pend_hit2, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
    input  pend_query1, pend_query2,
    output alu_ready, load_ready, WB_address_wr, WB_write_1, WB_data_wb_out1,
    output pend_hit1, pend_hit2, busy
  );

endinterface

// File: rtl/wb_fifo_2w1r.sv
// In-order FIFO accepting up to two entries and retiring one per cycle.
module wb_fifo_2w1r
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push0,
  input  logic             push1,
  input  wb_entry_t        din0,
  input  wb_entry_t        din1,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [DEPTH-1:0] entry_valid,
  output wb_entry_t        entries [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW-1:0]    slot1;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             do_pop;

  assign do_pop = pop & (count_q != '0);
  // din1 lands right behind din0, or at the tail when din0 is absent
  assign slot1  = wr_ptr_q + PW'(push0);

  always_comb begin
    valid_d = valid_q;
    if (do_pop) valid_d[rd_ptr_q] = 1'b0;
    if (push0)  valid_d[wr_ptr_q] = 1'b1;
    if (push1)  valid_d[slot1]    = 1'b1;
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(do_pop);
      wr_ptr_q <= wr_ptr_q + PW'(push0) + PW'(push1);
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q] <= din0;
    if (push1) mem_q[slot1]    <= din1;
  end

  assign head        = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign entry_valid = valid_q;
  assign entries     = mem_q;

  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: rtl/wb_writeback_unit.sv
// Merges ALU and load results into the register-file write port, in acceptance order.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW = wb_pkg::AW,
  parameter int unsigned DW = wb_pkg::DW,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  wb_writeback_unit_if.slave bus
);

  wb_entry_t        load_e, alu_e, first_e, din0, din1, head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [CW-1:0]    count;
  logic             empty, ready, acc_load, acc_alu, push0, push1, pop;

  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // Ready ignores the same-cycle pop so it depends on registered state only.
  assign ready    = (count <= CW'(DEPTH - 2));
  assign acc_load = bus.load_valid & ready & (bus.load_rd != '0);
  assign acc_alu  = bus.alu_valid & ready & (bus.alu_rd != '0);

  assign load_e  = '{rd: bus.load_rd, data: bus.load_data};
  assign alu_e   = '{rd: bus.alu_rd, data: bus.alu_data};
  // Load belongs to the older instruction, so it goes first.
  assign first_e = acc_load ? load_e : alu_e;

  always_comb begin
    pop    = 1'b0;
    push0  = 1'b0;
    push1  = 1'b0;
    din0   = first_e;
    din1   = alu_e;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (!empty) begin
      pop    = 1'b1;
      push0  = acc_load | acc_alu;
      push1  = acc_load & acc_alu;
      we_d   = 1'b1;
      addr_d = head.rd;
      data_d = head.data;
    end else if (acc_load | acc_alu) begin
      push0  = acc_load & acc_alu;
      din0   = alu_e;
      we_d   = 1'b1;
      addr_d = first_e.rd;
      data_d = first_e.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  wb_fifo_2w1r #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0       (push0),
    .push1       (push1),
    .din0        (din0),
    .din1        (din1),
    .pop         (pop),
    .head        (head),
    .empty       (empty),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  // The entry on WB_* has already left the FIFO, so it never matches here.
  always_comb begin
    bus.pend_hit1 = 1'b0;
    bus.pend_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entries[i].rd == bus.pend_query1) bus.pend_hit1 = 1'b1;
      if (entry_valid[i] && entries[i].rd == bus.pend_query2) bus.pend_hit2 = 1'b1;
    end
    if (bus.pend_query1 == '0) bus.pend_hit1 = 1'b0;
    if (bus.pend_query2 == '0) bus.pend_hit2 = 1'b0;
  end

  assign bus.alu_ready       = ready;
  assign bus.load_ready      = ready;
  assign bus.WB_write_1      = we_q;
  assign bus.WB_address_wr   = addr_q;
  assign bus.WB_data_wb_out1 = data_q;
  assign bus.busy            = ~empty | we_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Randomised and directed bench for wb_writeback_unit against a queue-based model.
module tb_wb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_writeback_unit_if bus ();

  wb_writeback_unit #(
    .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: entries waiting behind the write port, plus the write port itself.
  wb_entry_t     mq[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] rf_seen [32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hit(input logic [AW-1:0] q);
    if (q == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                      input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    wb_entry_t acc[$];
    wb_entry_t out;
    logic rdy;
    bus.load_valid  = lv;
    bus.load_rd     = lrd;
    bus.load_data   = ld;
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_data    = ad;
    bus.pend_query1 = q1;
    bus.pend_query2 = q2;
    #1;
    rdy = (mq.size() <= DEPTH - 2);
    check_eq("alu_ready", bus.alu_ready, rdy);
    check_eq("load_ready", bus.load_ready, rdy);
    check_eq("pend_hit1", bus.pend_hit1, model_hit(q1));
    check_eq("pend_hit2", bus.pend_hit2, model_hit(q2));
    @(posedge clk);
    if (lv && rdy && lrd != '0) acc.push_back('{rd: lrd, data: ld});
    if (av && rdy && ard != '0) acc.push_back('{rd: ard, data: ad});
    if (mq.size() != 0) begin
      out = mq.pop_front();
      m_we = 1'b1;
    end else if (acc.size() != 0) begin
      out = acc.pop_front();
      m_we = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (m_we) begin
      m_addr = out.rd;
      m_data = out.data;
    end
    while (acc.size() != 0) mq.push_back(acc.pop_front());
    #1;
    check_eq("WB_write_1", bus.WB_write_1, m_we);
    check_eq("WB_address_wr", bus.WB_address_wr, m_addr);
    check_eq("WB_data_wb_out1", bus.WB_data_wb_out1, m_data);
    check_eq("busy", bus.busy, (mq.size() != 0) || m_we);
    if (bus.WB_write_1) rf_seen[bus.WB_address_wr] = bus.WB_data_wb_out1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, AW'(i + 1), '0);
  endtask

  task automatic rand_step(input int pv, input int pz);
    logic [AW-1:0] lrd, ard;
    lrd = ($urandom_range(0, 99) < pz) ? '0 : AW'($urandom_range(1, 31));
    ard = ($urandom_range(0, 99) < pz) ? '0 : AW'($urandom_range(1, 31));
    step($urandom_range(0, 99) < pv, lrd, $urandom(),
         $urandom_range(0, 99) < pv, ard, $urandom(),
         AW'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0) ? lrd : ard);
  endtask

  initial begin
    bus.load_valid  = 1'b0;
    bus.load_rd     = '0;
    bus.load_data   = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.pend_query1 = '0;
    bus.pend_query2 = '0;
    foreach (rf_seen[i]) rf_seen[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we", bus.WB_write_1, 1'b0);
    check_eq("rst_addr", bus.WB_address_wr, '0);
    check_eq("rst_data", bus.WB_data_wb_out1, '0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_ready", bus.alu_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write, first edge after reset release.
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_00AA, 5'd5, '0);
    idle(2);

    // Simultaneous load and ALU: load first, ALU entry visible as pending.
    step(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd3);
    idle(2);

    // Both producers saturated for many pointer wraps.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, AW'($urandom_range(1, 31)), $urandom(),
           1'b1, AW'($urandom_range(1, 31)), $urandom(),
           AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end
    idle(6);

    // rd=0 is accepted but dropped.
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    idle(2);

    // Two writes to r9: last one wins, pending while the second is queued.
    step(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, '0);
    idle(1);
    check_eq("rf9_final", rf_seen[9], 32'h2);

    // Fill three entries, then reset asynchronously mid-cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, AW'(10 + i), $urandom(), 1'b1, AW'(20 + i), $urandom(), '0, '0);
    end
    check_eq("prefill_busy", bus.busy, 1'b1);
    bus.load_valid  = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.pend_query1 = 5'd22;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_we", bus.WB_write_1, 1'b0);
    check_eq("async_busy", bus.busy, 1'b0);
    check_eq("async_ready", bus.alu_ready, 1'b1);
    check_eq("async_hit", bus.pend_hit1, 1'b0);
    mq.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Random traffic in phases of varying pressure and rd=0 rate.
    for (int i = 0; i < 200; i++) rand_step(30, 5);
    for (int i = 0; i < 200; i++) rand_step(80, 10);
    for (int i = 0; i < 200; i++) rand_step(95, 30);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
